pipe_credit_ctrl: RTL and testbench

Handshake front/back end for a fixed-latency, ce-gated datapath built from single-bit and multi-bit shift-register delay stages.
- Upstream: accepts operands with valid/ready and issues the launch strobe and clock enable into the pipeline.
- Internally: tracks per-stage validity with its own valid delay line.
- Downstream: captures pipeline results into an output FIFO, using a credit scheme so the pipeline never has to stall for a downstream ready.

---
 rtl/pipe_credit_ctrl_if.sv | 28 ++
 rtl/pipe_credit_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_credit_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_credit_ctrl_if.sv
// Handshake bundle between pipe_credit_ctrl and its upstream source, pipeline and downstream sink.
// The master modport is the controller's view; the slave modport is the surrounding environment's view.
interface pipe_credit_ctrl_if #(
   parameter int C_DATA_WIDTH = 16,
   parameter int C_CNT_WIDTH  = 8
);
   logic                    en;
   logic                    in_valid;
   logic                    in_ready;
   logic                    pipe_ce;
   logic                    pipe_launch;
   logic [C_DATA_WIDTH-1:0] pipe_dout;
   logic                    out_valid;
   logic                    out_ready;
   logic [C_DATA_WIDTH-1:0] out_data;
   logic [C_CNT_WIDTH-1:0]  inflight_count;
   logic [C_CNT_WIDTH-1:0]  fifo_count;

   modport master (
      input  en, in_valid, pipe_dout, out_ready,
      output in_ready, pipe_ce, pipe_launch, out_valid, out_data, inflight_count, fifo_count
   );

   modport slave (
      output en, in_valid, pipe_dout, out_ready,
      input  in_ready, pipe_ce, pipe_launch, out_valid, out_data, inflight_count, fifo_count
   );
endinterface

// File: rtl/pipe_credit_ctrl.sv
// Credit-based front/back end for a fixed-latency ce-gated pipeline with a first-word fall-through output FIFO.
// Optional statistics counters (stall_cycles, accepted) are built when PIPE_CREDIT_STATS_EN is defined.
module pipe_credit_ctrl #(
   parameter int C_LATENCY    = 4,
   parameter int C_DATA_WIDTH = 16,
   parameter int C_FIFO_DEPTH = 8,
   parameter int C_CNT_WIDTH  = 8
) (
   input  logic                clk,
   input  logic                rst,
   pipe_credit_ctrl_if.master  bus
`ifdef PIPE_CREDIT_STATS_EN
   ,
   output logic [31:0]         stall_cycles,
   output logic [31:0]         accepted
`endif
);

   localparam int PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;

   logic [C_LATENCY-1:0]    r_vldSr;
   logic [C_CNT_WIDTH-1:0]  r_inflightCount;
   logic [C_CNT_WIDTH-1:0]  r_fifoCount;
   logic [PTR_W-1:0]        r_wrPtr;
   logic [PTR_W-1:0]        r_rdPtr;
   logic [C_DATA_WIDTH-1:0] r_mem [C_FIFO_DEPTH];
   logic [C_DATA_WIDTH-1:0] r_outData;

   logic                    w_inReady;
   logic                    w_launch;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_outValid;
   logic                    w_headIsPush;
   logic [C_CNT_WIDTH:0]    w_creditSum;
   logic [PTR_W-1:0]        w_rdPtrNext;
   logic [C_CNT_WIDTH-1:0]  w_fifoCountNext;

   // Every launched operand reserves a FIFO slot, so a result never finds the FIFO full.
   assign w_creditSum  = {1'b0, r_inflightCount} + {1'b0, r_fifoCount};
   assign w_inReady    = bus.en && !rst && (w_creditSum < (C_CNT_WIDTH+1)'(C_FIFO_DEPTH));
   assign w_launch     = bus.in_valid && w_inReady;
   assign w_push       = bus.en && r_vldSr[C_LATENCY-1];
   assign w_outValid   = (r_fifoCount != '0);
   assign w_pop        = w_outValid && bus.out_ready;
   assign w_rdPtrNext  = w_pop ? r_rdPtr + PTR_W'(1) : r_rdPtr;
   assign w_headIsPush = w_push && ((r_fifoCount == '0) || (w_pop && (r_fifoCount == C_CNT_WIDTH'(1))));

   always_comb begin
      w_fifoCountNext = r_fifoCount;
      case ({w_push, w_pop})
         2'b10:   w_fifoCountNext = r_fifoCount + C_CNT_WIDTH'(1);
         2'b01:   w_fifoCountNext = r_fifoCount - C_CNT_WIDTH'(1);
         default: w_fifoCountNext = r_fifoCount;
      endcase
   end

   // Valid line freezes with the pipeline whenever en is low.
   generate
      if (C_LATENCY == 1) begin : g_vldOne
         always_ff @(posedge clk) begin
            if (rst)         r_vldSr <= '0;
            else if (bus.en) r_vldSr <= w_launch;
         end
      end else begin : g_vldMany
         always_ff @(posedge clk) begin
            if (rst)         r_vldSr <= '0;
            else if (bus.en) r_vldSr <= {r_vldSr[C_LATENCY-2:0], w_launch};
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= bus.pipe_dout;
   end

   // out_data is registered with the head of the next cycle, bypassing the array when the push becomes the head.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflightCount <= '0;
         r_fifoCount     <= '0;
         r_wrPtr         <= '0;
         r_rdPtr         <= '0;
         r_outData       <= '0;
      end else begin
         case ({w_launch, w_push})
            2'b10:   r_inflightCount <= r_inflightCount + C_CNT_WIDTH'(1);
            2'b01:   r_inflightCount <= r_inflightCount - C_CNT_WIDTH'(1);
            default: r_inflightCount <= r_inflightCount;
         endcase
         r_fifoCount <= w_fifoCountNext;
         r_rdPtr     <= w_rdPtrNext;
         if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_fifoCountNext != '0) r_outData <= w_headIsPush ? bus.pipe_dout : r_mem[w_rdPtrNext];
      end
   end

   assign bus.in_ready       = w_inReady;
   assign bus.pipe_ce        = bus.en;
   assign bus.pipe_launch    = w_launch;
   assign bus.out_valid      = w_outValid;
   assign bus.out_data       = r_outData;
   assign bus.inflight_count = r_inflightCount;
   assign bus.fifo_count     = r_fifoCount;

`ifdef PIPE_CREDIT_STATS_EN
   logic [31:0] r_stallCycles;
   logic [31:0] r_accepted;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCycles <= '0;
         r_accepted    <= '0;
      end else begin
         if (bus.in_valid && !w_inReady && (r_stallCycles != '1)) r_stallCycles <= r_stallCycles + 32'd1;
         if (w_launch && (r_accepted != '1))                      r_accepted    <= r_accepted + 32'd1;
      end
   end

   assign stall_cycles = r_stallCycles;
   assign accepted     = r_accepted;
`endif

endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// Self-checking bench for pipe_credit_ctrl: directed scenarios plus randomized traffic against a token/queue model.
// The bench owns the ce-gated datapath that feeds pipe_dout.
module tb_pipe_credit_ctrl;

   localparam int L  = 4;
   localparam int W  = 16;
   localparam int D  = 8;
   localparam int CW = 8;

   typedef struct {
      int           remaining;
      logic [W-1:0] data;
   } token_t;

   logic clk = 1'b0;
   logic rst;
   logic [W-1:0] opIn;
   logic [W-1:0] pipeStage [L];

   token_t       inflQ[$];
   logic [W-1:0] fifoQ[$];
   logic [W-1:0] lastData;
   logic         expInReady;
   logic         expLaunch;
   int           checks   = 0;
   int           failures = 0;
   longint unsigned stallModel;
   longint unsigned accModel;

   always #5 clk = ~clk;

   pipe_credit_ctrl_if #(.C_DATA_WIDTH(W), .C_CNT_WIDTH(CW)) bus();

`ifdef PIPE_CREDIT_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] accepted;
`endif

   pipe_credit_ctrl #(
      .C_LATENCY   (L),
      .C_DATA_WIDTH(W),
      .C_FIFO_DEPTH(D),
      .C_CNT_WIDTH (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef PIPE_CREDIT_STATS_EN
      ,
      .stall_cycles(stall_cycles),
      .accepted    (accepted)
`endif
   );

   // Datapath under control: plain ce-gated delay line, junk enters when nothing is launched.
   always @(posedge clk) begin
      if (bus.pipe_ce) begin
         for (int i = L-1; i > 0; i--) pipeStage[i] <= pipeStage[i-1];
         pipeStage[0] <= bus.pipe_launch ? opIn : W'($urandom);
      end
   end
   assign bus.pipe_dout = pipeStage[L-1];

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic setInputs(input logic e, input logic iv, input logic ordy, input logic r, input logic [W-1:0] op);
      bus.en       = e;
      bus.in_valid = iv;
      bus.out_ready = ordy;
      rst          = r;
      opIn         = op;
      #1;
      expInReady = e && !r && ((inflQ.size() + fifoQ.size()) < D);
      expLaunch  = iv && expInReady;
   endtask

   task automatic tick();
      token_t t;
      @(posedge clk);
      if (rst) begin
         inflQ.delete();
         fifoQ.delete();
         lastData   = '0;
         stallModel = 0;
         accModel   = 0;
      end else begin
         if (bus.in_valid && !expInReady && stallModel < 64'hFFFF_FFFF) stallModel++;
         if (expLaunch && accModel < 64'hFFFF_FFFF) accModel++;
         if (fifoQ.size() > 0 && bus.out_ready) void'(fifoQ.pop_front());
         if (bus.en) begin
            foreach (inflQ[i]) inflQ[i].remaining--;
            while (inflQ.size() > 0 && inflQ[0].remaining == 0) begin
               t = inflQ.pop_front();
               fifoQ.push_back(t.data);
            end
         end
         if (expLaunch) begin
            t.remaining = L;
            t.data      = opIn;
            inflQ.push_back(t);
         end
         if (fifoQ.size() > 0) lastData = fifoQ[0];
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         setInputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
         tick();
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         setInputs(1'b1, 1'b1, 1'b0, 1'b1, 16'h5555);
         checks++;
         if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
         if (i > 0) begin
            checks += 3;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
            if (bus.inflight_count !== '0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", bus.inflight_count); end
            if (bus.fifo_count !== '0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", bus.fifo_count); end
         end
         tick();
      end
      setInputs(1'b1, 1'b1, 1'b0, 1'b0, 16'h0A0A);
      checks += 3;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", bus.in_ready); end
      if (bus.pipe_launch !== 1'b1) begin failures++; $display("FAIL reset_first_launch got=%0b exp=1", bus.pipe_launch); end
      if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
      tick();
      setInputs(1'b1, 1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (bus.inflight_count !== CW'(1)) begin failures++; $display("FAIL reset_inflight_after got=%0d exp=1", bus.inflight_count); end
      idle(12);
   endtask

   task automatic test_latency();
      setInputs(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234);
      checks++;
      if (bus.pipe_launch !== 1'b1) begin failures++; $display("FAIL lat_launch got=%0b exp=1", bus.pipe_launch); end
      tick();
      for (int k = 1; k <= L; k++) begin
         setInputs(1'b1, 1'b0, 1'b0, 1'b0, '0);
         checks += 2;
         if (bus.inflight_count !== CW'(1)) begin failures++; $display("FAIL lat_inflight k=%0d got=%0d exp=1", k, bus.inflight_count); end
         if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid k=%0d got=%0b exp=0", k, bus.out_valid); end
         tick();
      end
      setInputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
      checks += 3;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%0b exp=1", bus.out_valid); end
      if (bus.out_data !== 16'h1234) begin failures++; $display("FAIL lat_data got=%h exp=1234", bus.out_data); end
      if (bus.inflight_count !== '0) begin failures++; $display("FAIL lat_inflight_done got=%0d exp=0", bus.inflight_count); end
      tick();
      setInputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
      checks += 2;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_empty_valid got=%0b exp=0", bus.out_valid); end
      if (bus.out_data !== 16'h1234) begin failures++; $display("FAIL lat_hold_data got=%h exp=1234", bus.out_data); end
      tick();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] ops [20];
      int launches = 0;
      int got = 0;
      for (int i = 0; i < 20; i++) begin
         ops[i] = W'($urandom);
         setInputs(1'b1, 1'b1, 1'b0, 1'b0, ops[i]);
         if (bus.pipe_launch === 1'b1) launches++;
         tick();
      end
      setInputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
      checks += 4;
      if (launches != D) begin failures++; $display("FAIL bp_launches got=%0d exp=%0d", launches, D); end
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", bus.in_ready); end
      if (bus.fifo_count !== CW'(D)) begin failures++; $display("FAIL bp_fifo_count got=%0d exp=%0d", bus.fifo_count, D); end
      if (bus.inflight_count !== '0) begin failures++; $display("FAIL bp_inflight got=%0d exp=0", bus.inflight_count); end
      for (int i = 0; i < 12; i++) begin
         setInputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
         if (bus.out_valid === 1'b1) begin
            checks++;
            if (got >= D || bus.out_data !== ops[got]) begin
               failures++;
               $display("FAIL bp_order idx=%0d got=%h exp=%h", got, bus.out_data, (got < D) ? ops[got] : '0);
            end
            got++;
         end
         tick();
      end
      checks++;
      if (got != D) begin failures++; $display("FAIL bp_delivered got=%0d exp=%0d", got, D); end
   endtask

   task automatic test_enable_freeze();
      logic e;
      setInputs(1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
      tick();
      for (int k = 1; k <= L + 3; k++) begin
         e = !(k == 2 || k == 3);
         setInputs(e, 1'b0, 1'b0, 1'b0, '0);
         checks += 2;
         if (bus.pipe_ce !== e) begin failures++; $display("FAIL frz_ce k=%0d got=%0b exp=%0b", k, bus.pipe_ce, e); end
         if (!e && bus.in_ready !== 1'b0) begin failures++; $display("FAIL frz_in_ready k=%0d got=%0b exp=0", k, bus.in_ready); end
         if (k < L + 3) begin
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL frz_early_valid k=%0d got=%0b exp=0", k, bus.out_valid); end
         end else begin
            checks++;
            if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL frz_valid got=%0b exp=1", bus.out_valid); end
            if (bus.out_data !== 16'hBEEF) begin failures++; $display("FAIL frz_data got=%h exp=beef", bus.out_data); end
         end
         tick();
      end
      idle(4);
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] sent[$];
      logic [W-1:0] want;
      logic [W-1:0] op;
      for (int i = 0; i < 14; i++) begin
         op = W'($urandom);
         setInputs(1'b1, 1'b1, 1'b0, 1'b0, op);
         if (expLaunch) sent.push_back(op);
         tick();
      end
      for (int i = 0; i < 30; i++) begin
         op = W'($urandom);
         setInputs(1'b1, 1'b1, 1'b1, 1'b0, op);
         if (expLaunch) sent.push_back(op);
         checks += 2;
         if (bus.fifo_count !== CW'(fifoQ.size())) begin failures++; $display("FAIL sim_fifo_count i=%0d got=%0d exp=%0d", i, bus.fifo_count, fifoQ.size()); end
         if (bus.inflight_count !== CW'(inflQ.size())) begin failures++; $display("FAIL sim_inflight i=%0d got=%0d exp=%0d", i, bus.inflight_count, inflQ.size()); end
         if (bus.out_valid === 1'b1) begin
            want = sent.pop_front();
            checks++;
            if (bus.out_data !== want) begin failures++; $display("FAIL sim_order i=%0d got=%h exp=%h", i, bus.out_data, want); end
         end
         tick();
      end
      idle(14);
   endtask

   task automatic test_midop_reset();
      for (int i = 0; i < 5; i++) begin
         setInputs(1'b1, 1'b1, 1'b0, 1'b0, W'(16'hC000 + i));
         tick();
      end
      setInputs(1'b1, 1'b0, 1'b0, 1'b0, '0);
      tick();
      setInputs(1'b1, 1'b0, 1'b0, 1'b1, '0);
      checks += 3;
      if (bus.fifo_count !== CW'(2)) begin failures++; $display("FAIL mrst_pre_fifo got=%0d exp=2", bus.fifo_count); end
      if (bus.inflight_count !== CW'(3)) begin failures++; $display("FAIL mrst_pre_inflight got=%0d exp=3", bus.inflight_count); end
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mrst_in_ready got=%0b exp=0", bus.in_ready); end
      tick();
      setInputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
      checks += 4;
      if (bus.fifo_count !== '0) begin failures++; $display("FAIL mrst_fifo got=%0d exp=0", bus.fifo_count); end
      if (bus.inflight_count !== '0) begin failures++; $display("FAIL mrst_inflight got=%0d exp=0", bus.inflight_count); end
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%0b exp=0", bus.out_valid); end
      if (bus.out_data !== '0) begin failures++; $display("FAIL mrst_data got=%h exp=0000", bus.out_data); end
      for (int i = 0; i < 10; i++) begin
         tick();
         setInputs(1'b1, 1'b0, 1'b1, 1'b0, '0);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            failures++;
            $display("FAIL mrst_stale i=%0d valid=%0b data=%h exp valid=0 data=0000", i, bus.out_valid, bus.out_data);
         end
      end
      tick();
   endtask

   task automatic test_random();
      logic e, iv, ordy, r;
      for (int i = 0; i < 800; i++) begin
         e    = ($urandom_range(0, 9) < 8);
         iv   = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         r    = ($urandom_range(0, 199) == 0);
         setInputs(e, iv, ordy, r, W'($urandom));
         checks += 7;
         if (bus.in_ready !== expInReady) begin failures++; $display("FAIL rnd_in_ready i=%0d got=%0b exp=%0b", i, bus.in_ready, expInReady); end
         if (bus.pipe_launch !== expLaunch) begin failures++; $display("FAIL rnd_launch i=%0d got=%0b exp=%0b", i, bus.pipe_launch, expLaunch); end
         if (bus.pipe_ce !== e) begin failures++; $display("FAIL rnd_ce i=%0d got=%0b exp=%0b", i, bus.pipe_ce, e); end
         if (bus.out_valid !== (fifoQ.size() != 0)) begin failures++; $display("FAIL rnd_out_valid i=%0d got=%0b exp=%0b", i, bus.out_valid, fifoQ.size() != 0); end
         if (bus.out_data !== lastData) begin failures++; $display("FAIL rnd_out_data i=%0d got=%h exp=%h", i, bus.out_data, lastData); end
         if (bus.inflight_count !== CW'(inflQ.size())) begin failures++; $display("FAIL rnd_inflight i=%0d got=%0d exp=%0d", i, bus.inflight_count, inflQ.size()); end
         if (bus.fifo_count !== CW'(fifoQ.size())) begin failures++; $display("FAIL rnd_fifo_count i=%0d got=%0d exp=%0d", i, bus.fifo_count, fifoQ.size()); end
`ifdef PIPE_CREDIT_STATS_EN
         if (i > 0) begin
            checks += 2;
            if (stall_cycles !== 32'(stallModel)) begin failures++; $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, stall_cycles, stallModel); end
            if (accepted !== 32'(accModel)) begin failures++; $display("FAIL rnd_accepted i=%0d got=%0d exp=%0d", i, accepted, accModel); end
         end
`endif
         tick();
      end
   endtask

   initial begin
      bus.en        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      opIn          = '0;
      lastData      = '0;
      stallModel    = 0;
      accModel      = 0;
      @(negedge clk);
      test_reset();
      test_latency();
      test_backpressure();
      test_enable_freeze();
      test_simultaneous();
      test_midop_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
